// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM address width, opcodes, bubble word,
// instruction field positions and the fetch-sequencer state encoding.
package cpu_pkg;

   localparam int AW = 6;

   localparam logic [5:0]  OP_BEQ = 6'h0F;
   localparam logic [5:0]  OP_BNE = 6'h10;
   localparam logic [5:0]  OP_JMP = 6'h12;

   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int IMM_MSB = 25;
   localparam int IMM_LSB = 10;

   typedef enum logic {
      RUN     = 1'b0,
      WAIT_BR = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ctrl_target_calc.sv
// ID-stage control decode: classifies the IF/ID word as branch or jump and
// computes both candidate redirect targets. Purely combinational.
module ctrl_target_calc
   import cpu_pkg::*;
(
   input  logic [31:0]   if_id_inst,
   input  logic [AW-1:0] if_id_pc,
   output logic          is_br,
   output logic          is_jmp,
   output logic [AW-1:0] br_target,
   output logic [AW-1:0] jmp_target
);

   logic [5:0]  op;
   logic [15:0] imm;

   // Field extraction, opcode classification and target arithmetic.
   // Only the low AW bits of imm matter: the sum is taken modulo 2^AW.
   always_comb begin
      op         = if_id_inst[OPC_MSB:OPC_LSB];
      imm        = if_id_inst[IMM_MSB:IMM_LSB];
      is_br      = (op == OP_BEQ) || (op == OP_BNE);
      is_jmp     = (op == OP_JMP);
      br_target  = if_id_pc + AW'(1) + imm[AW-1:0];
      jmp_target = if_id_inst[AW-1:0];
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational
// instruction ROM and loads IF/ID. Jumps redirect from ID with one bubble;
// branches park fetch in WAIT_BR until EX resolves them.
// Optional build macro FETCH_STALL_CNT_EN adds saturating bubble/stall counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal fetch; honours hz_stall and ID jump/branch decode
//   WAIT_BR | branch in EX pending; PC held, IF/ID bubble until resolved
module fetch_sequencer
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   rom_inst,
   input  logic          hz_stall,
   input  logic          ex_br_valid,
   input  logic          ex_br_taken,
   output logic [AW-1:0] rom_addr,
   output logic [31:0]   if_id_inst,
   output logic [AW-1:0] if_id_pc,
   output logic          if_id_valid,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]   cnt_ctrl_bubble,
   output logic [15:0]   cnt_hz_stall,
`endif
   output logic          fetch_state
);

   fetch_state_t  state, state_nxt;
   logic [AW-1:0] pc, pc_nxt;
   logic [AW-1:0] br_target_q, br_target_nxt;
   logic [31:0]   inst_nxt;
   logic [AW-1:0] ipc_nxt;
   logic          valid_nxt;
   logic          ctrl_bubble;
   logic          run_stall;

   logic          dec_br, dec_jmp;
   logic [AW-1:0] dec_br_target, dec_jmp_target;
   logic          id_br, id_jmp;

   ctrl_target_calc u_ctrl_target_calc (
      .if_id_inst (if_id_inst),
      .if_id_pc   (if_id_pc),
      .is_br      (dec_br),
      .is_jmp     (dec_jmp),
      .br_target  (dec_br_target),
      .jmp_target (dec_jmp_target)
   );

   // A bubble in ID never decodes as control, even if its word were nonzero.
   assign id_br  = if_id_valid && dec_br;
   assign id_jmp = if_id_valid && dec_jmp;

   // State and datapath registers; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= '0;
         br_target_q <= '0;
         if_id_inst  <= NOP;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         br_target_q <= br_target_nxt;
         if_id_inst  <= inst_nxt;
         if_id_pc    <= ipc_nxt;
         if_id_valid <= valid_nxt;
      end
   end

   // Next-state: RUN enters WAIT_BR on a branch in ID, leaves on EX resolve.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (!hz_stall && !id_jmp && id_br) state_nxt = WAIT_BR;
         WAIT_BR: if (ex_br_valid)                   state_nxt = RUN;
         default:                                    state_nxt = RUN;
      endcase
   end

   // Datapath next values. Bubbles keep if_id_pc so it always names the
   // last instruction that occupied ID.
   always_comb begin
      pc_nxt        = pc;
      br_target_nxt = br_target_q;
      inst_nxt      = if_id_inst;
      ipc_nxt       = if_id_pc;
      valid_nxt     = if_id_valid;
      ctrl_bubble   = 1'b0;
      run_stall     = 1'b0;
      case (state)
         RUN: begin
            if (hz_stall) begin
               run_stall = 1'b1;
            end else if (id_jmp) begin
               pc_nxt      = dec_jmp_target;
               inst_nxt    = NOP;
               valid_nxt   = 1'b0;
               ctrl_bubble = 1'b1;
            end else if (id_br) begin
               br_target_nxt = dec_br_target;
               inst_nxt      = NOP;
               valid_nxt     = 1'b0;
               ctrl_bubble   = 1'b1;
            end else begin
               inst_nxt  = rom_inst;
               ipc_nxt   = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc + AW'(1);
            end
         end
         WAIT_BR: begin
            if (ex_br_valid && !ex_br_taken) begin
               inst_nxt  = rom_inst;
               ipc_nxt   = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc + AW'(1);
            end else begin
               if (ex_br_valid) pc_nxt = br_target_q;
               inst_nxt    = NOP;
               valid_nxt   = 1'b0;
               ctrl_bubble = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign rom_addr    = pc;
   assign fetch_state = state;

`ifdef FETCH_STALL_CNT_EN
   // Saturating event counters for control bubbles and load-use stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_ctrl_bubble <= '0;
         cnt_hz_stall    <= '0;
      end else begin
         if (ctrl_bubble && cnt_ctrl_bubble != 16'hFFFF)
            cnt_ctrl_bubble <= cnt_ctrl_bubble + 16'd1;
         if (run_stall && cnt_hz_stall != 16'hFFFF)
            cnt_hz_stall <= cnt_hz_stall + 16'd1;
      end
   end
`else
   logic unused_evt;
   assign unused_evt = ctrl_bubble ^ run_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each step drives inputs, pushes the
// expected post-edge state to a scoreboard queue, and pops/compares it after
// the edge.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   rom_inst;
   logic          hz_stall, ex_br_valid, ex_br_taken;
   logic [AW-1:0] rom_addr;
   logic [31:0]   if_id_inst;
   logic [AW-1:0] if_id_pc;
   logic          if_id_valid;
   logic          fetch_state;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0]   cnt_ctrl_bubble, cnt_hz_stall;
   logic [15:0]   snap_cb, snap_hz;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] rom [64];

   typedef struct {
      logic [AW-1:0] pc;
      logic          st;
      logic          valid;
      logic [31:0]   inst;
      logic [AW-1:0] ipc;
   } exp_t;

   exp_t sb[$];

   fetch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .rom_inst    (rom_inst),
      .hz_stall    (hz_stall),
      .ex_br_valid (ex_br_valid),
      .ex_br_taken (ex_br_taken),
      .rom_addr    (rom_addr),
      .if_id_inst  (if_id_inst),
      .if_id_pc    (if_id_pc),
      .if_id_valid (if_id_valid),
`ifdef FETCH_STALL_CNT_EN
      .cnt_ctrl_bubble (cnt_ctrl_bubble),
      .cnt_hz_stall    (cnt_hz_stall),
`endif
      .fetch_state (fetch_state)
   );

   always #5 clk = ~clk;

   always_comb rom_inst = rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, record expectations, clock, then compare.
   task automatic step(input logic r, input logic hz, input logic bv, input logic bt,
                       input int epc, input logic est, input logic ev,
                       input logic [31:0] einst, input int eipc);
      exp_t e, got;
      rst = r; hz_stall = hz; ex_br_valid = bv; ex_br_taken = bt;
      e.pc = AW'(epc); e.st = est; e.valid = ev; e.inst = einst; e.ipc = AW'(eipc);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(got.pc));
      chk("fetch_state", 32'(fetch_state), 32'(got.st));
      chk("if_id_valid", 32'(if_id_valid), 32'(got.valid));
      chk("if_id_inst", if_id_inst, got.inst);
      if (got.valid) chk("if_id_pc", 32'(if_id_pc), 32'(got.ipc));
   endtask

   task automatic run(input int k);
      step(0, 0, 0, 0, k + 1, 0, 1, rom[k], k);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0400_0100 + 32'(i);
      rom[6]  = 32'h4000_04c5;   // bne, target 8
      rom[8]  = 32'h4800_000a;   // jmp 10
      rom[10] = 32'h3fff_d821;   // beq, target 1
      rst = 1'b1; hz_stall = 1'b0; ex_br_valid = 1'b0; ex_br_taken = 1'b0;
      #1;

      // reset
      step(1, 0, 0, 0, 0, 0, 0, NOP, 0);
      step(1, 0, 0, 0, 0, 0, 0, NOP, 0);

      // straight-line fetch 0..6
      for (int k = 0; k <= 6; k++) run(k);
      // bne in ID -> WAIT_BR, then taken -> PC 8
      step(0, 0, 0, 0, 7, 1, 0, NOP, 0);
      step(0, 0, 1, 1, 8, 0, 0, NOP, 0);
      // jmp fetched, redirected to 10 with one bubble
      run(8);
      step(0, 0, 0, 0, 10, 0, 0, NOP, 0);
      // beq in ID -> WAIT_BR; hz_stall ignored while waiting
      run(10);
      step(0, 0, 0, 0, 11, 1, 0, NOP, 0);
      step(0, 1, 0, 0, 11, 1, 0, NOP, 0);
      step(0, 1, 0, 0, 11, 1, 0, NOP, 0);
      // reset mid-WAIT_BR overrides a pending resolve
      step(1, 0, 1, 1, 0, 0, 0, NOP, 0);
      step(1, 0, 0, 0, 0, 0, 0, NOP, 0);

      // restart: first fetch is rom[0]; run up to the bne again
      for (int k = 0; k <= 6; k++) run(k);
      step(0, 0, 0, 0, 7, 1, 0, NOP, 0);
      step(0, 0, 0, 0, 7, 1, 0, NOP, 0);
      // not taken: IF/ID = {rom[7], 7, 1}, PC 8
      step(0, 0, 1, 0, 8, 0, 1, rom[7], 7);
      run(8);
`ifdef FETCH_STALL_CNT_EN
      snap_cb = cnt_ctrl_bubble;
      snap_hz = cnt_hz_stall;
`endif
      // hz_stall holds the jump in ID for 3 cycles
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9, 0, 1, rom[8], 8);
      step(0, 0, 0, 0, 10, 0, 0, NOP, 0);
`ifdef FETCH_STALL_CNT_EN
      chk("cnt_hz_stall_delta", 32'(cnt_hz_stall - snap_hz), 32'd3);
      chk("cnt_ctrl_bubble_delta", 32'(cnt_ctrl_bubble - snap_cb), 32'd1);
`endif
      // beq taken -> target 1
      run(10);
      step(0, 0, 0, 0, 11, 1, 0, NOP, 0);
      step(0, 0, 1, 1, 1, 0, 0, NOP, 0);
      run(1);
      // hz_stall during ordinary fetch freezes PC and IF/ID
      step(0, 1, 0, 0, 2, 0, 1, rom[1], 1);
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
